multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 opcode  in  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  in  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  in  1  ALU result equals zero (combinational, from datapath).
REQ-007 RegDst, ALUSrcA, PCSrc, PCWrite, MemWrite, IorD, IRWrite, MomtoReg, RegWrite  out  1 each  datapath controls.
REQ-008 ALUControl  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-009 ALUSrcB  out  2  00 B register, 01 constant 4, 10 SignImm, 11 zero.
REQ-010 state_o  out  4  current FSM state code (debug).
REQ-011 retire_o  out  1  one-cycle pulse when an instruction completes.
REQ-012 instr_count  out  16  count of retired instructions.

Function
REQ-013 The block SHALL be a Moore FSM; only PCWrite in BRANCH SHALL depend on an input (zero).
REQ-014 States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-015 Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000.
REQ-016 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECUTE (R-type), BRANCH (beq), ADDIEXEC (addi), FETCH (any other opcode).
REQ-017 MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTE->ALUWB if funct is supported, else FETCH; ADDIEXEC->ADDIWB; MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB->FETCH.
REQ-018 Supported funct: add 100000, sub 100010, and 100100, or 100101, slt 101010.
REQ-019 Any output not listed for a state SHALL be 0; ALUSrcB defaults to 00 and ALUControl to 010.
REQ-020 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=0, IRWrite=1, PCWrite=1.
REQ-021 DECODE: ALUSrcA=0, ALUSrcB=10, ALUControl=010 (branch target into ALUOut).
REQ-022 MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
REQ-023 MEMREAD: IorD=1. MEMWRITE: IorD=1, MemWrite=1.
REQ-024 MEMWB: RegDst=0, MomtoReg=1, RegWrite=1. ADDIWB: RegDst=0, MomtoReg=0, RegWrite=1.
REQ-025 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from funct per REQ-008/REQ-018.
REQ-026 ALUWB: RegDst=1, MomtoReg=0, RegWrite=1.
REQ-027 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=1, PCWrite=zero.
REQ-028 retire_o SHALL be 1 for exactly one cycle in each of MEMWB, MEMWRITE, ALUWB, BRANCH and ADDIWB; it SHALL be 0 for an unsupported opcode or funct.
REQ-029 instr_count SHALL increment by 1 on each edge where retire_o=1 and SHALL wrap from 0xFFFF to 0x0000.
REQ-030 Instruction cycle counts: lw 5, sw 4, R-type 4, addi 4, beq 3, unsupported opcode 2, unsupported funct 3.

Reset
REQ-031 On a clock edge with reset=1: state=FETCH and instr_count=0, overriding any in-progress instruction.
REQ-032 While reset=1: PCWrite, IRWrite, MemWrite, RegWrite and retire_o SHALL be forced to 0; all other outputs follow the current state.
REQ-033 In the first cycle after reset deasserts, outputs SHALL be the FETCH values from REQ-020.

Verification
REQ-034 lw (opcode 100011): state sequence 0,1,2,3,4,0; MemWrite never 1; RegWrite=1 and MomtoReg=1 only in state 4; instr_count 0->1.
REQ-035 R-type sub (funct 100010): sequence 0,1,6,7,0; ALUControl=110 in state 6; RegDst=1 and RegWrite=1 in state 7.
REQ-036 beq with zero=1, then with zero=0: PCWrite=1 in state 8 for the first, 0 for the second; PCSrc=1 in both; retire_o pulses both times.
REQ-037 Unsupported opcode 000010 and R-type with funct 000000: return to FETCH after 2 and 3 cycles respectively; RegWrite and retire_o stay 0; instr_count is unchanged.
REQ-038 Assert reset for one cycle while in MEMWRITE: MemWrite=0 during reset; next state_o=0; instr_count=0.
REQ-039 Preload 0xFFFE retirements and issue 3 addi: instr_count goes 0xFFFF, 0x0000, 0x0001; sequence per addi is 0,1,9,10,0.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_unit
//
// Moore-style control FSM for a multi-cycle MIPS-like datapath. It walks each
// instruction through fetch, decode and the opcode-specific execute/memory/
// writeback steps, drives the datapath select and enable lines, and keeps a
// running count of retired instructions.
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-high reset
//   opcode       in   6   instruction bits [31:26]
//   funct        in   6   instruction bits [5:0]
//   zero         in   1   ALU result == 0 (only used for PCWrite in BRANCH)
//   RegDst .. RegWrite out 1 each  datapath control lines
//   ALUControl   out  3   010 add, 110 sub, 000 and, 001 or, 111 slt
//   ALUSrcB      out  2   00 B reg, 01 constant 4, 10 SignImm, 11 zero
//   state_o      out  4   current state code (debug)
//   retire_o     out  1   one-cycle pulse in the final state of an instruction
//   instr_count  out 16   retired-instruction counter, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module multi_cycle_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic        PCSrc,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        MomtoReg,
  output logic        RegWrite,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  state_o,
  output logic        retire_o,
  output logic [15:0] instr_count
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       funct_ok;
  logic [2:0] funct_alu;

  // R-type funct decode; unsupported functs fall back to add and are
  // aborted in EXECUTE without a writeback.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // Next-state logic; opcode/funct come from the instruction register so they
  // are stable from DECODE onward. Unused codes 11-15 recover to FETCH.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEXEC;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      EXECUTE:  next_state = funct_ok ? ALUWB : FETCH;
      ADDIEXEC: next_state = ADDIWB;
      default:  next_state = FETCH;
    endcase
  end

  // State register and retirement counter; reset overrides any instruction
  // in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      instr_count <= 16'd0;
    end else begin
      state <= next_state;
      if (retire_o) begin
        instr_count <= instr_count + 16'd1;
      end
    end
  end

  // Output decode from state only, except PCWrite in BRANCH which follows
  // zero. While reset is high the state-changing enables are suppressed but
  // the select lines still reflect the current state.
  always_comb begin
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    PCSrc      = 1'b0;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    MomtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUControl = ALU_ADD;
    ALUSrcB    = 2'b00;
    retire_o   = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      DECODE: ALUSrcB = 2'b10;
      MEMADR, ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD: IorD = 1'b1;
      MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        retire_o = 1'b1;
      end
      MEMWB: begin
        MomtoReg = 1'b1;
        RegWrite = 1'b1;
        retire_o = 1'b1;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        retire_o = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = funct_alu;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire_o = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        PCWrite    = zero;
        retire_o   = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      retire_o = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control_unit
//
// Directed bench for the multi-cycle control FSM. Inputs change and outputs
// are sampled on the falling clock edge, so every check sees settled values
// for the state entered at the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        RegDst;
  logic        ALUSrcA;
  logic        PCSrc;
  logic        PCWrite;
  logic        MemWrite;
  logic        IorD;
  logic        IRWrite;
  logic        MomtoReg;
  logic        RegWrite;
  logic [2:0]  ALUControl;
  logic [1:0]  ALUSrcB;
  logic [3:0]  state_o;
  logic        retire_o;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  multi_cycle_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .PCSrc       (PCSrc),
    .PCWrite     (PCWrite),
    .MemWrite    (MemWrite),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .MomtoReg    (MomtoReg),
    .RegWrite    (RegWrite),
    .ALUControl  (ALUControl),
    .ALUSrcB     (ALUSrcB),
    .state_o     (state_o),
    .retire_o    (retire_o),
    .instr_count (instr_count)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a broken run still terminates with a report
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive the instruction-register fields and zero flag
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic z);
    opcode = op;
    funct  = fn;
    zero   = z;
  endtask

  // One comparison: counts it and reports a mismatch
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // Advance to the next sampling point (falling edge after a rising edge)
  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);

    // Held in reset: FETCH state, enables suppressed, selects follow FETCH
    checkOutput("rst_state", state_o, 16'd0);
    checkOutput("rst_pcwrite", PCWrite, 16'd0);
    checkOutput("rst_irwrite", IRWrite, 16'd0);
    checkOutput("rst_retire", retire_o, 16'd0);
    checkOutput("rst_count", instr_count, 16'd0);
    checkOutput("rst_alusrcb", ALUSrcB, 16'd1);

    // First cycle after reset release shows FETCH values
    reset = 1'b0;
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    #1;
    checkOutput("fetch_pcwrite", PCWrite, 16'd1);
    checkOutput("fetch_irwrite", IRWrite, 16'd1);
    checkOutput("fetch_alusrcb", ALUSrcB, 16'd1);
    checkOutput("fetch_aluctl", ALUControl, 16'b010);
    checkOutput("fetch_iord", IorD, 16'd0);

    // lw: 0,1,2,3,4,0
    nextCycle();
    checkOutput("lw_s1", state_o, 16'd1);
    checkOutput("lw_dec_alusrcb", ALUSrcB, 16'd2);
    checkOutput("lw_dec_irwrite", IRWrite, 16'd0);
    nextCycle();
    checkOutput("lw_s2", state_o, 16'd2);
    checkOutput("lw_adr_alusrca", ALUSrcA, 16'd1);
    checkOutput("lw_adr_alusrcb", ALUSrcB, 16'd2);
    checkOutput("lw_adr_memwrite", MemWrite, 16'd0);
    nextCycle();
    checkOutput("lw_s3", state_o, 16'd3);
    checkOutput("lw_rd_iord", IorD, 16'd1);
    checkOutput("lw_rd_memwrite", MemWrite, 16'd0);
    checkOutput("lw_rd_regwrite", RegWrite, 16'd0);
    nextCycle();
    checkOutput("lw_s4", state_o, 16'd4);
    checkOutput("lw_wb_regwrite", RegWrite, 16'd1);
    checkOutput("lw_wb_memtoreg", MomtoReg, 16'd1);
    checkOutput("lw_wb_regdst", RegDst, 16'd0);
    checkOutput("lw_wb_retire", retire_o, 16'd1);
    checkOutput("lw_wb_memwrite", MemWrite, 16'd0);
    checkOutput("lw_wb_count", instr_count, 16'd0);
    nextCycle();
    checkOutput("lw_s0", state_o, 16'd0);
    checkOutput("lw_count", instr_count, 16'd1);
    checkOutput("lw_retire_off", retire_o, 16'd0);

    // R-type sub: 0,1,6,7,0
    applyStimulus(6'b000000, 6'b100010, 1'b0);
    nextCycle();
    checkOutput("sub_s1", state_o, 16'd1);
    nextCycle();
    checkOutput("sub_s6", state_o, 16'd6);
    checkOutput("sub_aluctl", ALUControl, 16'b110);
    checkOutput("sub_alusrca", ALUSrcA, 16'd1);
    checkOutput("sub_alusrcb", ALUSrcB, 16'd0);
    checkOutput("sub_ex_retire", retire_o, 16'd0);
    nextCycle();
    checkOutput("sub_s7", state_o, 16'd7);
    checkOutput("sub_regdst", RegDst, 16'd1);
    checkOutput("sub_regwrite", RegWrite, 16'd1);
    checkOutput("sub_memtoreg", MomtoReg, 16'd0);
    checkOutput("sub_retire", retire_o, 16'd1);
    nextCycle();
    checkOutput("sub_s0", state_o, 16'd0);
    checkOutput("sub_count", instr_count, 16'd2);

    // R-type or and slt: only the EXECUTE ALU code differs
    applyStimulus(6'b000000, 6'b100101, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("or_aluctl", ALUControl, 16'b001);
    nextCycle();
    nextCycle();
    checkOutput("or_count", instr_count, 16'd3);
    applyStimulus(6'b000000, 6'b101010, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("slt_aluctl", ALUControl, 16'b111);
    nextCycle();
    nextCycle();
    checkOutput("slt_count", instr_count, 16'd4);

    // beq taken: PCWrite follows zero while in BRANCH
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    nextCycle();
    checkOutput("beq1_s1", state_o, 16'd1);
    nextCycle();
    checkOutput("beq1_s8", state_o, 16'd8);
    checkOutput("beq1_pcwrite", PCWrite, 16'd1);
    checkOutput("beq1_pcsrc", PCSrc, 16'd1);
    checkOutput("beq1_aluctl", ALUControl, 16'b110);
    checkOutput("beq1_alusrcb", ALUSrcB, 16'd0);
    checkOutput("beq1_retire", retire_o, 16'd1);
    zero = 1'b0;
    #1;
    checkOutput("beq1_pcwrite_zero_drop", PCWrite, 16'd0);
    nextCycle();
    checkOutput("beq1_s0", state_o, 16'd0);
    checkOutput("beq1_count", instr_count, 16'd5);

    // beq not taken
    applyStimulus(6'b000100, 6'b000000, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("beq0_s8", state_o, 16'd8);
    checkOutput("beq0_pcwrite", PCWrite, 16'd0);
    checkOutput("beq0_pcsrc", PCSrc, 16'd1);
    checkOutput("beq0_retire", retire_o, 16'd1);
    nextCycle();
    checkOutput("beq0_s0", state_o, 16'd0);
    checkOutput("beq0_count", instr_count, 16'd6);

    // Unsupported opcode: back to FETCH after 2 cycles, nothing retired
    applyStimulus(6'b000010, 6'b000000, 1'b0);
    nextCycle();
    checkOutput("badop_s1", state_o, 16'd1);
    checkOutput("badop_regwrite", RegWrite, 16'd0);
    checkOutput("badop_retire", retire_o, 16'd0);
    nextCycle();
    checkOutput("badop_s0", state_o, 16'd0);
    checkOutput("badop_count", instr_count, 16'd6);

    // Unsupported funct: back to FETCH after 3 cycles, nothing retired
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("badfn_s6", state_o, 16'd6);
    checkOutput("badfn_regwrite", RegWrite, 16'd0);
    checkOutput("badfn_retire", retire_o, 16'd0);
    nextCycle();
    checkOutput("badfn_s0", state_o, 16'd0);
    checkOutput("badfn_count", instr_count, 16'd6);

    // sw, interrupted by a one-cycle reset while in MEMWRITE
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("sw_s2", state_o, 16'd2);
    nextCycle();
    checkOutput("sw_s5", state_o, 16'd5);
    checkOutput("sw_memwrite", MemWrite, 16'd1);
    checkOutput("sw_iord", IorD, 16'd1);
    checkOutput("sw_retire", retire_o, 16'd1);
    reset = 1'b1;
    #1;
    checkOutput("swrst_memwrite", MemWrite, 16'd0);
    checkOutput("swrst_retire", retire_o, 16'd0);
    checkOutput("swrst_iord", IorD, 16'd1);
    checkOutput("swrst_state", state_o, 16'd5);
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("swrst_s0", state_o, 16'd0);
    checkOutput("swrst_count", instr_count, 16'd0);
    checkOutput("swrst_irwrite", IRWrite, 16'd1);

    // Unused state code recovers to FETCH with all-default outputs
    dut.state = 4'd13;
    #1;
    checkOutput("bad_state_code", state_o, 16'd13);
    checkOutput("bad_state_regwrite", RegWrite, 16'd0);
    checkOutput("bad_state_pcwrite", PCWrite, 16'd0);
    checkOutput("bad_state_aluctl", ALUControl, 16'b010);
    nextCycle();
    checkOutput("bad_state_recover", state_o, 16'd0);

    // Counter wrap: preload 0xFFFE, then three addi
    dut.instr_count = 16'hFFFE;
    applyStimulus(6'b001000, 6'b000000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput("addi_s1", state_o, 16'd1);
      nextCycle();
      checkOutput("addi_s9", state_o, 16'd9);
      checkOutput("addi_ex_alusrca", ALUSrcA, 16'd1);
      checkOutput("addi_ex_alusrcb", ALUSrcB, 16'd2);
      nextCycle();
      checkOutput("addi_s10", state_o, 16'd10);
      checkOutput("addi_regwrite", RegWrite, 16'd1);
      checkOutput("addi_regdst", RegDst, 16'd0);
      checkOutput("addi_memtoreg", MomtoReg, 16'd0);
      checkOutput("addi_retire", retire_o, 16'd1);
      nextCycle();
      checkOutput("addi_s0", state_o, 16'd0);
      checkOutput("addi_count", instr_count, 16'hFFFF + 16'(k + 1) - 16'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
